// File: rtl/cordic_sequencer.sv
// Control sequencer for an iterative CORDIC datapath: IDLE -> LOAD -> ITER x N -> DONE.
// Optional vectoring mode (Mode / Y_sign inputs) enabled by CORDIC_SEQUENCER_VECTORING_EN.
module cordic_sequencer #(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Z_sign,
`ifdef CORDIC_SEQUENCER_VECTORING_EN
  input  logic             Mode,
  input  logic             Y_sign,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Load,
  output logic             Enable,
  output logic [CNT_W-1:0] Shift_amt,
  output logic [CNT_W-1:0] Atan_addr,
  output logic             Sub_x,
  output logic             Sub_y,
  output logic             Sub_z
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_dir_pos;

  assign w_last = (r_cnt == CNT_W'(ITERATIONS - 1));

`ifdef CORDIC_SEQUENCER_VECTORING_EN
  logic r_mode;

  // Mode is latched once per operation so mid-run changes cannot disturb it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_mode <= Mode;
    end
  end

  assign w_dir_pos = r_mode ? Y_sign : ~Z_sign;
`else
  assign w_dir_pos = ~Z_sign;
`endif

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Iteration counter; holds on the last iteration instead of wrapping
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_LOAD:  r_cnt <= '0;
        S_ITER:  if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ITER;
      S_ITER:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; direction selects follow the live sign input during ITER
  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    Load      = 1'b0;
    Enable    = 1'b0;
    Shift_amt = '0;
    Atan_addr = '0;
    Sub_x     = 1'b0;
    Sub_y     = 1'b0;
    Sub_z     = 1'b0;
    case (r_state)
      S_LOAD: begin
        Busy = 1'b1;
        Load = 1'b1;
      end
      S_ITER: begin
        Busy      = 1'b1;
        Enable    = 1'b1;
        Shift_amt = r_cnt;
        Atan_addr = r_cnt;
        Sub_x     = w_dir_pos;
        Sub_y     = ~w_dir_pos;
        Sub_z     = w_dir_pos;
      end
      S_DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: timeline table plus scoreboarded sequences
// driven through a small behavioural model of the sequencer.
module tb_cordic_sequencer;

  localparam int unsigned ITERATIONS = 16;
  localparam int unsigned CNT_W      = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             Z_sign = 1'b0;
  logic             Mode = 1'b0;
  logic             Y_sign = 1'b0;
  logic             Busy, Done, Load, Enable;
  logic [CNT_W-1:0] Shift_amt, Atan_addr;
  logic             Sub_x, Sub_y, Sub_z;

  cordic_sequencer #(.ITERATIONS(ITERATIONS), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Z_sign    (Z_sign),
`ifdef CORDIC_SEQUENCER_VECTORING_EN
    .Mode      (Mode),
    .Y_sign    (Y_sign),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Load      (Load),
    .Enable    (Enable),
    .Shift_amt (Shift_amt),
    .Atan_addr (Atan_addr),
    .Sub_x     (Sub_x),
    .Sub_y     (Sub_y),
    .Sub_z     (Sub_z)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic             busy;
    logic             load;
    logic             enable;
    logic             done;
    logic [CNT_W-1:0] shift;
    logic [CNT_W-1:0] atan;
    logic             sx;
    logic             sy;
    logic             sz;
  } exp_t;

  typedef struct {
    logic start;
    logic zsign;
    exp_t exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t tbl[22];

  // Reference model state
  int   m_state = 0;  // 0 idle, 1 load, 2 iter, 3 done
  int   m_cnt   = 0;
  logic m_mode  = 1'b0;

  // Last sampled DUT outputs for sequence-level checks
  logic g_busy, g_en, g_done;
  int   cyc_no;

  function automatic exp_t model_exp(input logic zs, input logic ys);
    exp_t e;
    logic dpos;
    e = '0;
    dpos = ~zs;
`ifdef CORDIC_SEQUENCER_VECTORING_EN
    if (m_mode) dpos = ys;
`endif
    case (m_state)
      1: begin e.busy = 1'b1; e.load = 1'b1; end
      2: begin
        e.busy = 1'b1; e.enable = 1'b1;
        e.shift = CNT_W'(m_cnt); e.atan = CNT_W'(m_cnt);
        e.sx = dpos; e.sy = ~dpos; e.sz = dpos;
      end
      3: begin e.busy = 1'b1; e.done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, push expectation, compare mid-cycle, advance model
  task automatic cyc(input string nm, input logic st, input logic zs, input logic rs,
                     input logic md, input logic ys, input logic use_tbl, input exp_t tbl_exp);
    exp_t e, got;
    @(negedge Clk);
    Start = st; Z_sign = zs; Reset = rs; Mode = md; Y_sign = ys;
    if (rs) begin m_state = 0; m_cnt = 0; m_mode = 1'b0; end
    sb_q.push_back(use_tbl ? tbl_exp : model_exp(zs, ys));
    #2;
    got = {Busy, Load, Enable, Done, Shift_amt, Atan_addr, Sub_x, Sub_y, Sub_z};
    e = sb_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc_no, got, e);
    end
    g_busy = Busy; g_en = Enable; g_done = Done;
    @(posedge Clk);
    if (!rs) begin
      case (m_state)
        0: if (st) m_state = 1;
        1: begin m_cnt = 0; m_mode = md; m_state = 2; end
        2: if (m_cnt == int'(ITERATIONS) - 1) m_state = 3; else m_cnt++;
        3: m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  initial begin
    int en_cnt, done_cnt, d1, d2, busy19;
    logic zs;

    // Single-operation timeline with Z_sign alternating each cycle
    for (int c = 0; c < 22; c++) begin
      logic dpos;
      tbl[c].start = (c == 0);
      tbl[c].zsign = 1'(c % 2);
      dpos = ~tbl[c].zsign;
      tbl[c].exp = '0;
      if (c == 1) begin tbl[c].exp.busy = 1'b1; tbl[c].exp.load = 1'b1; end
      if (c >= 2 && c <= 17) begin
        tbl[c].exp.busy = 1'b1; tbl[c].exp.enable = 1'b1;
        tbl[c].exp.shift = CNT_W'(c - 2); tbl[c].exp.atan = CNT_W'(c - 2);
        tbl[c].exp.sx = dpos; tbl[c].exp.sy = ~dpos; tbl[c].exp.sz = dpos;
      end
      if (c == 18) begin tbl[c].exp.busy = 1'b1; tbl[c].exp.done = 1'b1; end
    end

    cyc_no = 0;
    for (int c = 0; c < 3; c++) cyc("reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 2; c++) cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    for (int c = 0; c < 22; c++) begin
      cyc_no = c;
      cyc("tbl", tbl[c].start, tbl[c].zsign, 1'b0, 1'b0, 1'b0, 1'b1, tbl[c].exp);
    end

    // Start re-pulsed at counter=5 (cycle 7) and in DONE (cycle 18) is ignored
    en_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("restart", (c == 0 || c == 7 || c == 18), zs, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (g_en) en_cnt++;
      if (g_done) done_cnt++;
    end
    chk("restart_enables", en_cnt, 16);
    chk("restart_dones", done_cnt, 1);

    // Start held high for 40 cycles: back-to-back with one IDLE cycle
    d1 = -1; d2 = -1; busy19 = -1;
    for (int c = 0; c < 40; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("held", 1'b1, zs, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (g_done && d1 < 0) d1 = c;
      else if (g_done && d2 < 0) d2 = c;
      if (c == 19) busy19 = int'(g_busy);
    end
    chk("held_done1", d1, 18);
    chk("held_done2", d2, 37);
    chk("held_idle19_busy", busy19, 0);
    for (int c = 0; c < 20; c++) cyc("drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset at counter=7 (cycle 9), no Done, no restart without a new Start
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("midreset", (c == 0), zs, (c == 9 || c == 10), 1'b0, 1'b0, 1'b0, '0);
      if (g_done) done_cnt++;
    end
    chk("midreset_no_done", done_cnt, 0);

    d1 = -1;
    for (int c = 0; c < 22; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("after_reset", (c == 0), zs, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (g_done && d1 < 0) d1 = c;
    end
    chk("after_reset_done", d1, 18);

`ifdef CORDIC_SEQUENCER_VECTORING_EN
    // Vectoring: Y_sign steers direction, Z_sign ignored, Mode toggles mid-ITER ignored
    for (int c = 0; c < 22; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("vect", (c == 0), zs, 1'b0, (c < 2 || c > 9), (c < 12), 1'b0, '0);
    end
    for (int c = 0; c < 22; c++) begin
      cyc_no = c;
      zs = 1'($urandom_range(0, 1));
      cyc("rot_mode_flip", (c == 0), zs, 1'b0, (c > 4), 1'b1, 1'b0, '0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 SHALL have parameter ITERATIONS, default 16, meaning the number of micro-rotations per operation (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the iteration counter and shift amount (ceil(log2(ITERATIONS))).
REQ-003 SHALL have port Clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port Reset, input, 1, an asynchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1, an operation request, sampled only in IDLE.
REQ-006 SHALL have port Z_sign, input, 1, the sign bit of the current Z residue (1 = negative).
REQ-007 SHALL have port Busy, output, 1, high from Start acceptance through the DONE state inclusive.
REQ-008 SHALL have port Done, output, 1, a one-cycle pulse when the results are valid.
REQ-009 SHALL have port Load, output, 1, a one-cycle strobe selecting the initial X/Y/Z into the datapath registers.
REQ-010 SHALL have port Enable, output, 1, driving the ADD_SUB Enable of the X, Y and Z stages.
REQ-011 SHALL have port Shift_amt, output, CNT_W, the arithmetic right-shift amount i for Shifted_x/Shifted_y.
REQ-012 SHALL have port Atan_addr, output, CNT_W, the atan(2^-i) LUT index (equal to Shift_amt).
REQ-013 SHALL have ports Sub_x, Sub_y, Sub_z, output, 1 each, per-stage add/subtract selects (1 = subtract).

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, ITER and DONE.
REQ-015 SHALL transition as follows: IDLE->LOAD when Start=1; LOAD->ITER unconditionally; ITER->DONE when the counter equals ITERATIONS-1; DONE->IDLE unconditionally.
REQ-016 SHALL assert Load=1 only in LOAD, Enable=1 only in ITER, and Done=1 only in DONE.
REQ-017 SHALL assert Busy=1 in the LOAD, ITER and DONE states.
REQ-018 SHALL clear the counter to 0 in LOAD, increment it by 1 per ITER cycle, and never wrap inside ITER.
REQ-019 SHALL drive Shift_amt and Atan_addr from the counter in ITER, and hold them at 0 in all other states.
REQ-020 SHALL compute direction combinationally in the ITER cycle from the current input: d=+1 when Z_sign=0, else d=-1.
REQ-021 SHALL drive d=+1 as Sub_x=1, Sub_y=0, Sub_z=1, and d=-1 as Sub_x=0, Sub_y=1, Sub_z=0.
REQ-022 SHALL hold Sub_x, Sub_y and Sub_z at 0 outside ITER.
REQ-023 SHALL assert Done exactly ITERATIONS+2 cycles after the Start-sampling edge, with exactly ITERATIONS Enable cycles per operation.
REQ-024 SHALL ignore Start while Busy=1, including a Start in the DONE cycle; there is no queuing.
REQ-025 SHALL, when Start is held high continuously, run back-to-back operations with one IDLE cycle between DONE and the next LOAD.

Reset
REQ-026 SHALL, on Reset=1 at any time (including mid-ITER), immediately force state=IDLE and counter=0, with all outputs 0.
REQ-027 SHALL, on deassertion of Reset, require Start to be asserted again before any new operation begins.

Configuration
REQ-028 SHALL provide the macro CORDIC_SEQUENCER_VECTORING_EN, which adds inputs Mode (1 = vectoring) and Y_sign.
REQ-029 SHALL, with CORDIC_SEQUENCER_VECTORING_EN defined and Mode=1, compute d=+1 when Y_sign=1 and d=-1 when Y_sign=0, with Z_sign ignored; Mode is captured in LOAD and held for the whole operation.
REQ-030 SHALL, without CORDIC_SEQUENCER_VECTORING_EN, omit the Mode and Y_sign ports and operate in rotation mode only.

Verification
REQ-031 SHALL cover: reset then one Start pulse with Z_sign=0 -> Load at cycle 1, Enable for cycles 2..17, Shift_amt 0..15, Done at cycle 18, Busy low at cycle 19.
REQ-032 SHALL cover: Z_sign alternating 0/1 per ITER cycle -> Sub_x/Sub_y/Sub_z toggle in lockstep per REQ-021 every cycle.
REQ-033 SHALL cover: Start re-pulsed at ITER counter=5 and in the DONE cycle -> no effect, with exactly 16 Enable cycles.
REQ-034 SHALL cover: Start held high for 40 cycles -> Done at cycles 18 and 37, with a single IDLE cycle at 19.
REQ-035 SHALL cover: Reset pulsed at ITER counter=7 -> all outputs 0 in the same cycle, Done never asserted, and the next Start yields a full 18-cycle run.
REQ-036 SHALL cover, when CORDIC_SEQUENCER_VECTORING_EN is defined: Mode=1 with Y_sign=1 -> Sub_x=1, Sub_y=0, Sub_z=1, independent of Z_sign; Mode changed mid-ITER -> no effect.
